// File: rtl/pio_pkg.sv
// Shared constants for the PIO register blocks: bus width, register addresses, edge encodings.
package pio_pkg;

    localparam int unsigned BUS_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH = 2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_RESERVED = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_EDGECAP  = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave port of the input PIO: register access strobes, read data and interrupt.
interface pio_in_edge_capture_if;

    logic [pio_pkg::ADDR_WIDTH-1:0] address;
    logic                           chipselect;
    logic                           read_n;
    logic                           write_n;
    logic [pio_pkg::BUS_WIDTH-1:0]  writedata;
    logic [pio_pkg::BUS_WIDTH-1:0]  readdata;
    logic                           irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pio_in_edge_capture_sync_edge_detect.sv
// Two-flop synchronizer for the fabric input field plus a one-cycle history stage for per-bit edge detection.
module sync_edge_detect
    import pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned EDGE_TYPE  = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] sync_data,
    output logic [DATA_WIDTH-1:0] edge_pulse
);

    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edge is seen while prev still holds the pre-change value.
    always_comb begin
        edge_pulse = '0;
        case (EDGE_TYPE)
            EDGE_FALLING: edge_pulse = ~sync2 & prev;
            EDGE_ANY:     edge_pulse = sync2 ^ prev;
            default:      edge_pulse = sync2 & ~prev;
        endcase
    end

    assign sync_data = sync2;

endmodule

// File: rtl/pio_in_edge_capture.sv
// Input PIO with sticky per-bit edge capture and a maskable level interrupt on an Avalon-MM slave port.
module pio_in_edge_capture
    import pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned EDGE_TYPE  = EDGE_RISING
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_in_edge_capture_if.slave    avs,
    input  logic [DATA_WIDTH-1:0]   in_port
);

    logic [DATA_WIDTH-1:0] sync_data;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] edgecap_next_c;
    logic [DATA_WIDTH-1:0] clear_mask_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [BUS_WIDTH-1:0]  rd_mux_c;
    logic                  wr_strobe_c;
    logic                  rd_strobe_c;

    sync_edge_detect #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge_detect (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_data  (sync_data),
        .edge_pulse (edge_pulse)
    );

    assign wr_strobe_c = avs.chipselect & ~avs.write_n;
    assign rd_strobe_c = avs.chipselect & ~avs.read_n;
    assign wdata_c     = avs.writedata[DATA_WIDTH-1:0];

    if (DATA_WIDTH < BUS_WIDTH) begin : g_wdata_upper
        logic unused_wdata_upper;
        assign unused_wdata_upper = ^avs.writedata[BUS_WIDTH-1:DATA_WIDTH];
    end

    // Write-1-to-clear; a fresh edge in the same cycle keeps its bit set.
    always_comb begin
        clear_mask_c = '0;
        if (wr_strobe_c && (avs.address == ADDR_EDGECAP)) begin
            clear_mask_c = wdata_c;
        end
        edgecap_next_c = (edgecap & ~clear_mask_c) | edge_pulse;
    end

    always_comb begin
        rd_mux_c = '0;
        case (avs.address)
            ADDR_DATA:    rd_mux_c = BUS_WIDTH'(sync_data);
            ADDR_IRQMASK: rd_mux_c = BUS_WIDTH'(irqmask);
            ADDR_EDGECAP: rd_mux_c = BUS_WIDTH'(edgecap);
            default:      rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            edgecap <= edgecap_next_c;
            if (wr_strobe_c && (avs.address == ADDR_IRQMASK)) begin
                irqmask <= wdata_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
            avs.irq      <= 1'b0;
        end else begin
            avs.irq <= |(edgecap & irqmask);
            if (rd_strobe_c) begin
                avs.readdata <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Directed-vector bench with a scoreboard: stimulus queues expectations, a monitor checks readdata/irq after each edge.
module tb_pio_in_edge_capture;
    import pio_pkg::*;

    localparam int unsigned DW = 6;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] in_port;
    logic          irq_probe;

    exp_t rd_q[$];
    exp_t irq_q[$];
    int   n_cmp;
    int   n_err;
    logic fire;
    logic probe;

    pio_in_edge_capture_if bus ();

    pio_in_edge_capture #(
        .DATA_WIDTH (DW),
        .EDGE_TYPE  (EDGE_RISING)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus.slave),
        .in_port (in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample strobes at the edge, compare registered outputs just after it.
    always @(posedge clk) begin
        exp_t e;
        fire  = bus.chipselect && !bus.read_n && reset_n;
        probe = irq_probe;
        #1;
        if (fire) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: readdata=0x%08h with no expectation queued", bus.readdata);
            end else begin
                e = rd_q.pop_front();
                if (bus.readdata !== e.val) begin
                    n_err++;
                    $display("FAIL %s: readdata got 0x%08h expected 0x%08h", e.name, bus.readdata, e.val);
                end
            end
        end
        if (probe) begin
            n_cmp++;
            if (irq_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_irq_probe: irq=%0b with no expectation queued", bus.irq);
            end else begin
                e = irq_q.pop_front();
                if (32'(bus.irq) !== e.val) begin
                    n_err++;
                    $display("FAIL %s: irq got %0b expected %0d", e.name, bus.irq, e.val);
                end
            end
        end
    end

    // All tasks are entered at a negedge and return at the following negedge.
    task automatic rd(input logic [1:0] a, input logic [31:0] exp_val, input string nm);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        rd_q.push_back('{nm, exp_val});
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic irq_chk(input logic exp_val, input string nm);
        irq_probe = 1'b1;
        irq_q.push_back('{nm, 32'(exp_val)});
        @(negedge clk);
        irq_probe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset_n        = 1'b0;
        in_port        = '0;
        irq_probe      = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Reset defaults
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0, "rst_irqmask");
        rd(2'd2, 32'h0, "rst_reserved");
        rd(2'd3, 32'h0, "rst_edgecap");
        irq_chk(1'b0, "rst_irq");

        // Rising capture and IRQ
        wr(2'd1, 32'h05);
        in_port = 6'h05;
        idle(2);
        irq_chk(1'b0, "irq_not_yet");
        irq_chk(1'b1, "irq_rise_latency");
        rd(2'd3, 32'h05, "edgecap_05");
        rd(2'd0, 32'h05, "data_05");
        wr(2'd3, 32'h01);
        rd(2'd3, 32'h04, "edgecap_after_clr1");
        irq_chk(1'b1, "irq_held_bit2");
        wr(2'd3, 32'h04);
        irq_chk(1'b0, "irq_low_after_clr");
        rd(2'd3, 32'h00, "edgecap_cleared");

        // Mask gating; falling edges ignored for rising capture
        wr(2'd1, 32'h00);
        in_port = 6'h00;
        idle(3);
        rd(2'd3, 32'h00, "falling_not_captured");
        in_port = 6'h3F;
        idle(3);
        rd(2'd3, 32'h3F, "edgecap_3f");
        irq_chk(1'b0, "irq_masked");
        wr(2'd1, 32'h20);
        irq_chk(1'b1, "irq_unmask_1cyc");
        rd(2'd1, 32'h20, "irqmask_20");

        // Set beats clear on the same cycle
        wr(2'd3, 32'h3F);
        in_port = 6'h3B;
        idle(3);
        rd(2'd3, 32'h00, "edgecap_pre_race");
        in_port = 6'h3F;
        idle(2);
        wr(2'd3, 32'h04);
        rd(2'd3, 32'h04, "set_beats_clear");
        irq_chk(1'b0, "irq_race_masked");

        // DATA path, read latency, ignored writes, zero extension
        in_port = 6'h2A;
        idle(3);
        rd(2'd0, 32'h2A, "data_2a");
        wr(2'd0, 32'hFF);
        rd(2'd0, 32'h2A, "data_write_ignored");
        wr(2'd2, 32'hFF);
        rd(2'd2, 32'h00, "reserved_write_ignored");
        wr(2'd1, 32'hFFFF_FF20);
        rd(2'd1, 32'h20, "irqmask_upper_ignored");
        in_port = 6'h15;
        idle(1);
        rd(2'd0, 32'h2A, "data_sync_latency_old");
        rd(2'd0, 32'h15, "data_sync_latency_new");
        rd(2'd3, 32'h15, "edgecap_15");

        // Mid-operation asynchronous reset
        wr(2'd1, 32'h3F);
        in_port = 6'h00;
        idle(3);
        in_port = 6'h3F;
        idle(3);
        rd(2'd3, 32'h3F, "edgecap_pre_reset");
        irq_chk(1'b1, "irq_pre_reset");
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        rd(2'd3, 32'h00, "edgecap_after_reset");
        rd(2'd1, 32'h00, "irqmask_after_reset");
        irq_chk(1'b0, "irq_after_reset");
        rd(2'd3, 32'h3F, "edgecap_high_at_release");
        rd(2'd0, 32'h3F, "data_after_reset");

        idle(2);
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d read / %0d irq expectations left, expected 0", rd_q.size(), irq_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_capture.md
# pio_in_edge_capture

Avalon-MM slave input port: the read-direction counterpart of the processor's output PIO registers. It brings an asynchronous DATA_WIDTH-bit field from FPGA fabric into the clk domain and exposes it to the soft processor. It detects edges per bit into a sticky capture register and raises a maskable level interrupt. It sits on the processor's Avalon data bus, beside the output PIOs that configure the signal-processing chain.

## Interface
- DATA_WIDTH, 6: width of in_port and of the data, mask and capture registers (1..32).
- EDGE_TYPE, 0: per-bit edge that sets capture. 0 = rising, 1 = falling, 2 = any.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of the register.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data. Bits above DATA_WIDTH are ignored.
- in_port  in  DATA_WIDTH  asynchronous input field from fabric.
- readdata  out  32  registered read data. Zero-extended above DATA_WIDTH.
- irq  out  1  level interrupt, registered.

## Operation
- Register map:
  - Address 0 DATA: read-only, returns the synchronized in_port. Writes are ignored.
  - Address 1 IRQMASK: read/write. A bit set to 1 enables that bit's capture onto irq.
  - Address 2: reserved, reads 0, writes ignored.
  - Address 3 EDGECAP: read returns the capture register. A write clears every bit where writedata is 1 (write-1-to-clear).
- Synchronizer: 2-flop chain, sync1 then sync2. An edge-detect stage holds prev = sync2 delayed one cycle.
- Edge detect per bit:
  - rising = sync2 & ~prev
  - falling = ~sync2 & prev
  - any = sync2 ^ prev
- Capture bit sets when its edge is detected. It stays set until cleared by a write.
- Simultaneous edge and clear on the same bit in the same cycle: set wins, and the bit stays 1.
- irq_next = OR-reduction of (edgecap & irqmask). irq is a register.
- Write strobe: chipselect & ~write_n. Read strobe: chipselect & ~read_n.
- readdata updates only on a read strobe. It holds its previous value otherwise.
- Reset values, all zero:
  - readdata = 0, irq = 0.
  - irqmask = 0, edgecap = 0.
  - sync1, sync2 and prev = 0.
  - A high in_port at reset release therefore produces a rising edge, and capture sets, after the synchronizer latency.
- Reset asserted mid-operation clears all state immediately, asynchronously. No pending capture survives it.
- No waitrequest. Every access completes in one cycle.

## Timing
- Read latency: 1 cycle. readdata is valid on the cycle after the read strobe (Avalon readLatency = 1).
- Write takes effect at the strobe clock edge.
  - A read of the same register in the next cycle returns the new value.
- in_port to DATA visibility:
  - An in_port change before edge N appears in sync2 after edge N+1.
  - readdata reflects it for a read strobe at edge N+2 or later.
- in_port change to edgecap set: edge N+2, because the edge is seen while prev still holds the old value.
- edgecap or irqmask change to irq: 1 cycle.
  - Clear-write at edge K gives irq low after edge K+1, unless another enabled capture is still set.
- Input pulses shorter than one clk period may be missed. This is allowed and not checked.

## Structure
- Shared package pio_pkg holds:
  - Address constants ADDR_DATA = 0, ADDR_IRQMASK = 1, ADDR_EDGECAP = 3.
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY encodings.
- Sub-module sync_edge_detect (parameterized by DATA_WIDTH and EDGE_TYPE):
  - Contains the 2-flop synchronizer, the prev register and the edge logic.
  - Outputs sync_data and edge_pulse.
- Top level contains the register file, the read mux with its registered readdata, and the irq register.

## Test plan
- Reset and defaults: drive in_port = 0, release reset, read addresses 0 to 3. All return 0x00000000 and irq = 0.
- Rising capture and IRQ:
  - Write IRQMASK = 0x05, then drive in_port 0x00 -> 0x05.
  - EDGECAP reads 0x05 and irq rises within 4 cycles.
  - Write EDGECAP = 0x01: it reads 0x04 and irq stays 1.
  - Write 0x04: irq = 0 one cycle later.
- Mask gating: with IRQMASK = 0x00, toggle in_port 0x00 -> 0x3F. EDGECAP = 0x3F and irq stays 0. Writing IRQMASK = 0x20 gives irq = 1 after 1 cycle.
- Set-beats-clear: an in_port bit-2 edge reaches the detector in the same cycle as a write EDGECAP = 0x04. The following read returns bit 2 = 1.
- Read latency and DATA: in_port = 0x2A held for 3+ cycles. A read at address 0 returns 0x0000002A exactly one cycle after the strobe. A write of 0xFF to address 0 leaves the read value unchanged.
- Mid-operation reset: with EDGECAP = 0x3F and irq = 1, pulse reset_n low for 1 ns between edges. readdata, irq, IRQMASK and EDGECAP all read 0 afterwards.
